sr_pulse_driver: RTL
====================

Name: sr_pulse_driver

Overview:
- Produces well-formed set/reset pulse pairs (s, r) to drive an SR storage latch from a request handshake.
- Guarantees the following:
  - s and r are never high together.
  - Every pulse has a fixed width.
  - A dead time follows every pulse.
  - The latch output is read back after the dead time to confirm it switched.
- Sits between control logic (request side) and an SR latch (pulse side). It tracks the expected latch state and flags mismatches.

Parameters:
PULSE_W, 4, cycles s or r is held high per request (>=1)
DEAD_W, 3, cycles both s and r are low after a pulse before the next request (>=3, covers q_fb synchronizer latency)
CNT_W, 4, timer width; must hold max(PULSE_W, DEAD_W)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  block can accept a request (high only in IDLE)
req_set  input  1  request direction: 1 = set latch, 0 = reset latch
q_fb  input  1  latch output read back, asynchronous to clk
err_clr  input  1  clears sticky error flag
s  output  1  set pulse to latch (registered)
r  output  1  reset pulse to latch (registered)
busy  output  1  high in PULSE or DEAD
q_exp  output  1  expected latch state
err  output  1  sticky readback mismatch flag

Behaviour:
- Reset (async, rst_n=0):
  - s=0, r=0, q_exp=0, err=0, busy=0.
  - State goes to IDLE, so req_ready=1. Timer = 0.
  - Takes effect immediately, including mid-pulse.
- States: IDLE, PULSE, DEAD.
- IDLE:
  - req_ready=1.
  - Accept occurs when req_valid=1 at a clock edge. Capture dir=req_set and load timer = PULSE_W-1.
  - Next state PULSE. q_exp<=req_set.
- PULSE:
  - s=dir, r=~dir (registered, so visible the cycle after accept). req_ready=0.
  - Timer decrements each cycle. When timer==0: s,r<=0, timer<=DEAD_W-1, go to DEAD.
- DEAD:
  - s=r=0. Timer decrements each cycle.
  - When timer==0, sample the synchronized q_fb. If it differs from dir, set err. Go to IDLE.
- Latency (accept at edge ending cycle T):
  - s or r high cycles T+1..T+PULSE_W.
  - Low cycles T+PULSE_W+1..T+PULSE_W+DEAD_W.
  - req_ready high again cycle T+PULSE_W+DEAD_W+1.
- Back-to-back: a request held valid is accepted on the first IDLE cycle. No extra bubble.
- Requests while busy: not accepted, no side effects. The requester must hold req_valid and req_set stable until accepted.
- Redundant request (req_set==q_exp): a full pulse is still issued (refresh).
- Invariant: s&r==0 in every cycle, including reset entry/exit.
- err:
  - Sticky.
  - err_clr=1 clears it.
  - A new mismatch in the same cycle as err_clr wins, so err stays 1.
- q_fb passes through a 2-flop synchronizer before comparison. It is never used combinationally.
- Timer arithmetic is unsigned CNT_W-bit and never decrements below 0.

Decomposition:
- Shared package sr_pkg holds:
  - the state enum typedef (IDLE, PULSE, DEAD);
  - default PULSE_W/DEAD_W constants;
  - the dir encoding constants (DIR_SET=1, DIR_RESET=0).
- One sub-module, sync_2ff: a 1-bit, 2-flop synchronizer with async active-low reset to 0, used for q_fb.

Test Plan (defaults PULSE_W=4, DEAD_W=3; bench latch model driven by s/r feeds q_fb):
- Reset: rst_n=0 for 3 cycles -> s=0, r=0, q_exp=0, err=0, busy=0, req_ready=1 during and after reset.
- Single set: req_valid=1, req_set=1 accepted at edge ending cycle 10 -> expected response:
  - s=1 cycles 11–14, r=0 throughout;
  - both low cycles 15–17;
  - q_exp=1 from cycle 11, err=0;
  - req_ready=1 at cycle 18.
- Back-to-back: set then reset held valid -> expected response:
  - reset accepted at edge ending cycle 18; r=1 cycles 19–22;
  - q_exp=0 from 19; s&r never 1 in any cycle;
  - no accept while req_ready=0.
- Fault/err: q_fb forced 0 during a set -> expected response:
  - err=1 from cycle 18 and holds across a subsequent good operation;
  - err_clr pulse -> err=0;
  - err_clr coincident with a new mismatch -> err remains 1.
- Reset mid-pulse: rst_n=0 during cycle 12 of a set -> expected response:
  - s drops to 0 without waiting for a clock edge;
  - after release: IDLE, q_exp=0, req_ready=1;
  - next set request produces a full 4-cycle pulse.
- Redundant request: set issued while q_exp=1 -> full 4-cycle s pulse, err=0, q_exp stays 1.

Source files
------------

// File: rtl/sr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sr_pkg
// Description : Shared types and constants for the SR latch pulse driver.
//               - state_t   : controller state encoding (IDLE, PULSE, DEAD)
//               - DEF_*     : default pulse width, dead time and timer width
//               - DIR_*     : request direction encoding
// Revision    : 1.0 - initial release
// ============================================================================
package sr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_DEAD  = 2'd2
    } state_t;

    localparam int DEF_PULSE_W = 4;
    localparam int DEF_DEAD_W  = 3;
    localparam int DEF_CNT_W   = 4;

    localparam logic DIR_SET   = 1'b1;
    localparam logic DIR_RESET = 1'b0;

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : 1-bit two-flop synchronizer, async active-low reset to 0.
// Ports       : clk    - destination clock
//               rst_n  - asynchronous active-low reset
//               i_d    - asynchronous input
//               o_q    - synchronized output (two clk cycles of latency)
// Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/sr_pulse_driver.sv
`default_nettype none
// ============================================================================
// Module      : sr_pulse_driver
// Description : Turns a valid/ready request into a fixed-width set or reset
//               pulse for an SR latch, followed by a dead time in which both
//               drives are low. At the end of the dead time the synchronized
//               latch readback is compared with the requested direction and a
//               sticky error is raised on mismatch.
// Ports       : clk       - system clock, rising edge
//               rst_n     - asynchronous active-low reset
//               req_valid - request present
//               req_ready - request can be accepted (IDLE only)
//               req_set   - request direction: 1 = set, 0 = reset
//               q_fb      - latch output readback (asynchronous)
//               err_clr   - clears the sticky error flag
//               s, r      - registered set/reset pulses to the latch
//               busy      - pulse or dead time in progress
//               q_exp     - expected latch state
//               err       - sticky readback mismatch flag
// Revision    : 1.0 - initial release
// ============================================================================
module sr_pulse_driver
    import sr_pkg::*;
#(
    parameter int PULSE_W = DEF_PULSE_W,
    parameter int DEAD_W  = DEF_DEAD_W,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_valid,
    output logic req_ready,
    input  logic req_set,
    input  logic q_fb,
    input  logic err_clr,
    output logic s,
    output logic r,
    output logic busy,
    output logic q_exp,
    output logic err
);

    localparam logic [CNT_W-1:0] C_PULSE_LOAD = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0] C_DEAD_LOAD  = CNT_W'(DEAD_W - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_timer;
    logic             r_dir;
    logic             w_q_sync;
    logic             w_mismatch;

    sync_2ff u_sync_q_fb (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (q_fb),
        .o_q   (w_q_sync)
    );

    // Readback is judged only on the last dead-time cycle, by which point the
    // synchronizer has had at least DEAD_W cycles to settle on the new value.
    assign w_mismatch = (r_state == ST_DEAD) && (r_timer == '0) && (w_q_sync != r_dir);

    assign req_ready = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_timer <= '0;
            r_dir   <= DIR_RESET;
            s       <= 1'b0;
            r       <= 1'b0;
            q_exp   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_dir   <= req_set;
                        q_exp   <= req_set;
                        r_timer <= C_PULSE_LOAD;
                        // s and r come from one direction bit, so they can
                        // never be driven high together.
                        s       <= (req_set == DIR_SET);
                        r       <= (req_set != DIR_SET);
                        r_state <= ST_PULSE;
                    end
                end
                ST_PULSE: begin
                    if (r_timer == '0) begin
                        s       <= 1'b0;
                        r       <= 1'b0;
                        r_timer <= C_DEAD_LOAD;
                        r_state <= ST_DEAD;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                ST_DEAD: begin
                    if (r_timer == '0) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                default: begin
                    s       <= 1'b0;
                    r       <= 1'b0;
                    r_timer <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // A fresh mismatch takes priority over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (w_mismatch) begin
            err <= 1'b1;
        end else if (err_clr) begin
            err <= 1'b0;
        end
    end

endmodule
`default_nettype wire
